axi_wr_arbiter: RTL and testbench
=================================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_OUTST, default 8, range 1..15: maximum writes accepted on slave AW but not yet answered on slave B.
REQ-002 aclk  in  1  single clock; all logic on rising edge.
REQ-003 aresetn  in  1  asynchronous, active-low reset.
REQ-004 m_awvalid  in  2  bit i = master i AW valid.
REQ-005 m_awready  out  2  bit i = master i AW accepted.
REQ-006 m_awpay  in  100  master i AW payload at [50i+49:50i] = {awid[8:0], awaddr[31:0], awlen[3:0], awsize[2:0], awburst[1:0]}; masters drive awid[8]=0.
REQ-007 m_wvalid / m_wlast  in  2 each  per-master W valid and last.
REQ-008 m_wready  out  2  per-master W ready.
REQ-009 m_wpay  in  144  master i W payload at [72i+71:72i] = {wdata[63:0], wstrb[7:0]}.
REQ-010 m_bvalid  out  2  per-master B valid.
REQ-011 m_bready  in  2  per-master B ready.
REQ-012 m_bresp / m_bid  out  2 / 9  shared B payload, copy of s_bresp and s_bid with bit 8 forced to 0.
REQ-013 s_awvalid, s_awpay  out  1, 50  slave AW valid and payload.
REQ-014 s_awready  in  1  slave AW ready.
REQ-015 s_wvalid, s_wlast, s_wpay  out  1, 1, 72  slave W.
REQ-016 s_wready  in  1  slave W ready.
REQ-017 s_bvalid, s_bresp, s_bid  in  1, 2, 9  slave B.
REQ-018 s_bready  out  1  slave B ready.

Function
REQ-019 The FSM SHALL have states IDLE, ADDR and DATA.
REQ-020 IDLE: if any m_awvalid and outst_cnt < MAX_OUTST, register grant index g, go to ADDR; otherwise stay.
REQ-021 ADDR: s_awvalid=1 and s_awpay = granted payload with awid[8] replaced by g; on s_awvalid&&s_awready, m_awready[g]=1 combinationally for that cycle, go to DATA.
REQ-022 s_awvalid SHALL first assert the cycle after the grant is registered (one-cycle grant latency) and SHALL stay asserted with stable payload until accepted.
REQ-023 DATA: s_wvalid/s_wlast/s_wpay = master g W signals; m_wready[g] = s_wready; other master's m_wready = 0; on W handshake with wlast go to IDLE.
REQ-024 W beats of a non-granted master SHALL be held off (ready 0) regardless of its wvalid.
REQ-025 Arbitration without WARB_FIXED_PRIO_EN: round-robin; after each completed AW handshake the priority pointer moves to the other master.
REQ-026 B routing: m_bvalid[s_bid[8]] = s_bvalid, other bit 0; s_bready = m_bready[s_bid[8]]; purely combinational.
REQ-027 outst_cnt (4 bits): +1 on slave AW handshake, -1 on slave B handshake, unchanged if both occur in the same cycle; never wraps.
REQ-028 A slave B handshake with outst_cnt = 0 SHALL be ignored by the counter (saturate at 0).
REQ-029 m_awready and m_wready SHALL be 0 in IDLE; s_wvalid SHALL be 0 outside DATA.

Reset
REQ-030 On aresetn low: state IDLE, g=0, priority pointer on master 0, outst_cnt=0, s_awvalid=0, s_wvalid=0, all m_*ready=0, immediately and asynchronously.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; no residual beats forwarded after release.

Configuration
REQ-032 With WARB_FIXED_PRIO_EN defined, master 0 SHALL always win simultaneous requests; without it, REQ-025 round-robin applies.

Verification
REQ-033 Both masters request at once, awlen=3, round-robin build -> master 0 granted, 4 W beats with s_wlast on the 4th, then master 1 granted.
REQ-034 Master 1 drives wvalid while master 0 owns DATA -> m_wready[1]=0 until master 0 wlast handshake completes.
REQ-035 MAX_OUTST=2, no B returned, 3 single-beat writes -> third AW stalled in IDLE; one s_bvalid with s_bid=9'h100 -> m_bvalid=2'b10, third AW granted next cycle.
REQ-036 Slave AW handshake and B handshake in the same cycle with outst_cnt=1 -> outst_cnt stays 1.
REQ-037 aresetn dropped during beat 2 of awlen=7 burst -> all valids/readies 0 at once; after release, state IDLE and outst_cnt=0.
REQ-038 WARB_FIXED_PRIO_EN build, both masters requesting continuously -> master 0 granted on every arbitration.

Source files
------------

// File: rtl/axi_wr_arbiter_if.sv
// Bus bundle for axi_wr_arbiter: two upstream AXI write masters plus one downstream slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's.
interface axi_wr_arbiter_if;
  logic [1:0]   m_awvalid;
  logic [1:0]   m_awready;
  logic [99:0]  m_awpay;
  logic [1:0]   m_wvalid;
  logic [1:0]   m_wlast;
  logic [1:0]   m_wready;
  logic [143:0] m_wpay;
  logic [1:0]   m_bvalid;
  logic [1:0]   m_bready;
  logic [1:0]   m_bresp;
  logic [8:0]   m_bid;
  logic         s_awvalid;
  logic         s_awready;
  logic [49:0]  s_awpay;
  logic         s_wvalid;
  logic         s_wlast;
  logic         s_wready;
  logic [71:0]  s_wpay;
  logic         s_bvalid;
  logic [1:0]   s_bresp;
  logic [8:0]   s_bid;
  logic         s_bready;

  modport slave (
    input  m_awvalid, m_awpay, m_wvalid, m_wlast, m_wpay, m_bready,
           s_awready, s_wready, s_bvalid, s_bresp, s_bid,
    output m_awready, m_wready, m_bvalid, m_bresp, m_bid,
           s_awvalid, s_awpay, s_wvalid, s_wlast, s_wpay, s_bready
  );

  modport master (
    output m_awvalid, m_awpay, m_wvalid, m_wlast, m_wpay, m_bready,
           s_awready, s_wready, s_bvalid, s_bresp, s_bid,
    input  m_awready, m_wready, m_bvalid, m_bresp, m_bid,
           s_awvalid, s_awpay, s_wvalid, s_wlast, s_wpay, s_bready
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write arbiter with outstanding-write limit and B routing on awid[8].
// Define WARB_FIXED_PRIO_EN for fixed master-0 priority; default is round-robin.
module axi_wr_arbiter #(
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_wr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [3:0] MaxOutst = 4'(MAX_OUTST);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic [3:0]  outst_q, outst_d;
  logic        pick;

  logic [1:0]  m_awready, m_wready, m_bvalid;
  logic        s_awvalid, s_wvalid, s_wlast, s_bready;
  logic [49:0] s_awpay;
  logic [48:0] aw_sel;
  logic [71:0] s_wpay;
  logic        aw_hs, b_hs, aw_inc, b_dec, b_sel;

`ifdef WARB_FIXED_PRIO_EN
  assign pick = ~bus.m_awvalid[0];
`else
  logic prio_q;

  // Pointer only matters on a tie; it flips to the other master after every slave AW handshake.
  assign pick = (&bus.m_awvalid) ? prio_q : bus.m_awvalid[1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prio_q <= 1'b0;
    end else if (aw_hs) begin
      prio_q <= ~grant_q;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    m_awready = '0;
    m_wready  = '0;
    s_awvalid = 1'b0;
    s_awpay   = '0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_wpay    = '0;
    aw_sel    = grant_q ? bus.m_awpay[98:50] : bus.m_awpay[48:0];
    case (state_q)
      IDLE: begin
        if ((|bus.m_awvalid) && (outst_q < MaxOutst)) begin
          grant_d = pick;
          state_d = ADDR;
        end
      end
      ADDR: begin
        s_awvalid = 1'b1;
        s_awpay   = {grant_q, aw_sel};
        if (bus.s_awready) begin
          m_awready[grant_q] = 1'b1;
          state_d            = DATA;
        end
      end
      DATA: begin
        s_wvalid          = bus.m_wvalid[grant_q];
        s_wlast           = bus.m_wlast[grant_q];
        s_wpay            = grant_q ? bus.m_wpay[143:72] : bus.m_wpay[71:0];
        m_wready[grant_q] = bus.s_wready;
        if (s_wvalid && bus.s_wready && s_wlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign b_sel    = bus.s_bid[8];
  assign m_bvalid = b_sel ? {bus.s_bvalid, 1'b0} : {1'b0, bus.s_bvalid};
  assign s_bready = bus.m_bready[b_sel];

  assign aw_hs  = s_awvalid & bus.s_awready;
  assign b_hs   = bus.s_bvalid & s_bready;
  assign aw_inc = aw_hs && (outst_q != 4'hF);
  assign b_dec  = b_hs && (outst_q != 4'h0);

  always_comb begin
    outst_d = outst_q;
    case ({aw_inc, b_dec})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      outst_q <= outst_d;
    end
  end

  assign bus.m_awready = m_awready;
  assign bus.m_wready  = m_wready;
  assign bus.m_bvalid  = m_bvalid;
  assign bus.m_bresp   = bus.s_bresp;
  assign bus.m_bid     = {1'b0, bus.s_bid[7:0]};
  assign bus.s_awvalid = s_awvalid;
  assign bus.s_awpay   = s_awpay;
  assign bus.s_wvalid  = s_wvalid;
  assign bus.s_wlast   = s_wlast;
  assign bus.s_wpay    = s_wpay;
  assign bus.s_bready  = s_bready;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter (MAX_OUTST=2); honours WARB_FIXED_PRIO_EN.
module tb_axi_wr_arbiter;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  axi_wr_arbiter_if bus();

  axi_wr_arbiter #(.MAX_OUTST(2)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

`ifdef WARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [49:0] awp(input logic [8:0] id, input logic [31:0] a, input logic [3:0] len);
    return {id, a, len, 3'd3, 2'd1};
  endfunction

  function automatic logic [1:0] oh(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [49:0] p0a, p1a, p0b, pe, sp;
    logic g2, g3, ge;

    aresetn = 1'b0;
    bus.m_awvalid = '0; bus.m_awpay = '0; bus.m_wvalid = '0; bus.m_wlast = '0;
    bus.m_wpay = '0; bus.m_bready = '0; bus.s_awready = 1'b0; bus.s_wready = 1'b0;
    bus.s_bvalid = 1'b0; bus.s_bresp = '0; bus.s_bid = '0;
    #12;
    chk("rst_s_awvalid", bus.s_awvalid, 0);
    chk("rst_s_wvalid", bus.s_wvalid, 0);
    chk("rst_m_awready", bus.m_awready, 0);
    chk("rst_m_wready", bus.m_wready, 0);
    chk("rst_outst", dut.outst_q, 0);
    tick();
    aresetn = 1'b1;

    // Both masters request; master 0 has a 4-beat burst
    p0a = awp(9'h012, 32'h0000_1000, 4'd3);
    p1a = awp(9'h034, 32'h0000_2000, 4'd0);
    bus.m_awpay = {p1a, p0a};
    bus.m_awvalid = 2'b11;
    bus.s_wready = 1'b1;
    #1;
    chk("grant_latency", bus.s_awvalid, 0);
    tick();
    chk("aw1_valid", bus.s_awvalid, 1);
    chk("aw1_pay", bus.s_awpay, {1'b0, p0a[48:0]});
    chk("aw1_ready_held", bus.m_awready, 2'b00);
    bus.s_awready = 1'b1;
    #1;
    chk("aw1_m_awready", bus.m_awready, 2'b01);
    tick();
    bus.s_awready = 1'b0;
    bus.m_awvalid = 2'b10;
    bus.m_wvalid = 2'b11;
    bus.m_wlast = 2'b10;
    bus.m_wpay[143:72] = {64'hBAD0_BAD0_BAD0_BAD0, 8'hFF};
    for (int k = 0; k < 4; k++) begin
      bus.m_wpay[71:0] = {64'hA0 + 64'(k), 8'h0F};
      bus.m_wlast[0] = (k == 3);
      #1;
      chk("w1_m_wready", bus.m_wready, 2'b01);
      chk("w1_s_wpay", bus.s_wpay, {64'hA0 + 64'(k), 8'h0F});
      chk("w1_s_wlast", bus.s_wlast, (k == 3) ? 1 : 0);
      tick();
    end

    p0b = awp(9'h056, 32'h0000_3000, 4'd0);
    bus.m_awpay = {p1a, p0b};
    bus.m_awvalid = 2'b11;
    #1;
    chk("idle_m_wready", bus.m_wready, 2'b00);
    chk("idle_s_wvalid", bus.s_wvalid, 0);
    chk("outst_after1", dut.outst_q, 1);
    g2 = FIXED ? 1'b0 : 1'b1;
    g3 = ~g2;
    tick();
    pe = g2 ? p1a : p0b;
    chk("aw2_pay", bus.s_awpay, {g2, pe[48:0]});
    bus.s_awready = 1'b1;
    #1;
    chk("aw2_m_awready", bus.m_awready, oh(g2));
    tick();
    bus.s_awready = 1'b0;
    bus.m_awvalid[g2] = 1'b0;
    bus.m_wvalid = 2'b11;
    bus.m_wlast = 2'b11;
    bus.m_wpay = {64'h1111, 8'h11, 64'h2222, 8'h22};
    #1;
    chk("w2_m_wready", bus.m_wready, oh(g2));
    chk("w2_s_wpay", bus.s_wpay, g2 ? {64'h1111, 8'h11} : {64'h2222, 8'h22});
    tick();
    bus.m_wvalid = 2'b00;

    // Limit reached: remaining request must stall
    chk("outst_full", dut.outst_q, 2);
    tick();
    chk("stall1", bus.s_awvalid, 0);
    tick();
    chk("stall2", bus.s_awvalid, 0);
    bus.s_bvalid = 1'b1;
    bus.s_bid = 9'h100;
    bus.s_bresp = 2'b10;
    bus.m_bready = 2'b10;
    #1;
    chk("b_m_bvalid", bus.m_bvalid, 2'b10);
    chk("b_s_bready", bus.s_bready, 1);
    chk("b_m_bid", bus.m_bid, 9'h000);
    chk("b_m_bresp", bus.m_bresp, 2'b10);
    tick();
    bus.s_bvalid = 1'b0;
    bus.m_bready = 2'b00;
    #1;
    chk("b_no_grant_yet", bus.s_awvalid, 0);
    chk("outst_after_b", dut.outst_q, 1);
    tick();
    pe = g3 ? p1a : p0b;
    chk("aw3_valid", bus.s_awvalid, 1);
    chk("aw3_pay", bus.s_awpay, {g3, pe[48:0]});

    // AW and B handshakes in the same cycle
    bus.s_awready = 1'b1;
    bus.s_bvalid = 1'b1;
    bus.s_bid = 9'h000;
    bus.m_bready = 2'b01;
    #1;
    chk("same_m_bvalid", bus.m_bvalid, 2'b01);
    chk("same_m_awready", bus.m_awready, oh(g3));
    tick();
    bus.s_awready = 1'b0;
    bus.s_bvalid = 1'b0;
    bus.m_bready = 2'b00;
    bus.m_awvalid = 2'b00;
    #1;
    chk("outst_same_cycle", dut.outst_q, 1);
    bus.m_wvalid[g3] = 1'b1;
    tick();
    bus.m_wvalid = 2'b00;
    bus.s_bvalid = 1'b1;
    bus.m_bready = 2'b01;
    tick();
    chk("outst_drained", dut.outst_q, 0);
    tick();
    chk("outst_saturate", dut.outst_q, 0);
    bus.s_bvalid = 1'b0;
    bus.m_bready = 2'b00;

    // Reset during beat 2 of an 8-beat burst
    bus.m_awpay[49:0] = awp(9'h078, 32'h0000_4000, 4'd7);
    bus.m_awvalid = 2'b01;
    tick();
    bus.s_awready = 1'b1;
    tick();
    bus.s_awready = 1'b0;
    bus.m_awvalid = 2'b00;
    bus.m_wvalid = 2'b01;
    bus.m_wlast = 2'b00;
    tick();
    tick();
    chk("burst_beat2_valid", bus.s_wvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("arst_s_wvalid", bus.s_wvalid, 0);
    chk("arst_m_wready", bus.m_wready, 2'b00);
    chk("arst_m_awready", bus.m_awready, 2'b00);
    chk("arst_s_awvalid", bus.s_awvalid, 0);
    chk("arst_outst", dut.outst_q, 0);
    tick();
    aresetn = 1'b1;
    tick();
    chk("post_rst_s_wvalid", bus.s_wvalid, 0);
    chk("post_rst_m_wready", bus.m_wready, 2'b00);
    chk("post_rst_outst", dut.outst_q, 0);
    bus.m_wvalid = 2'b00;

    // Continuous requests from both masters
    bus.m_awpay = {p1a, p0b};
    bus.m_awvalid = 2'b11;
    bus.m_wlast = 2'b11;
    for (int r = 0; r < 4; r++) begin
      ge = FIXED ? 1'b0 : r[0];
      tick();
      sp = bus.s_awpay;
      chk("arb_grant", sp[49], ge);
      bus.s_awready = 1'b1;
      #1;
      chk("arb_m_awready", bus.m_awready, oh(ge));
      tick();
      bus.s_awready = 1'b0;
      bus.m_wvalid = 2'b11;
      bus.s_bvalid = 1'b1;
      bus.s_bid = {ge, 8'h00};
      bus.m_bready = 2'b11;
      #1;
      chk("arb_m_wready", bus.m_wready, oh(ge));
      chk("arb_m_bvalid", bus.m_bvalid, oh(ge));
      tick();
      bus.m_wvalid = 2'b00;
      bus.s_bvalid = 1'b0;
      bus.m_bready = 2'b00;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
